// File: rtl/mem_loader.sv
// Program loader: takes a length-prefixed byte stream and writes it into RAM
// from base_addr onward while holding the CPU, then pulses reset_cycle/done.
module mem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              mem_we,
    output logic              cpu_hold,
    output logic              reset_cycle,
    output logic              done,
    output logic              busy,
    output logic [2:0]        state_dbg
);

    // Stream handshake: a byte moves on a cycle where in_valid and in_ready
    // are both 1; in_ready is high only while waiting for a length or data byte.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEN     = 3'd1,
        DATA    = 3'd2,
        WRITE   = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] base;
    logic [7:0]        idx;
    logic [7:0]        len;
    logic              xfer;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        in_ready    = 1'b0;
        mem_we      = 1'b0;
        reset_cycle = 1'b0;
        done        = 1'b0;
        busy        = 1'b1;
        xfer        = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = LEN;
            end
            LEN: begin
                in_ready = 1'b1;
                xfer     = in_valid;
                if (in_valid) state_next = (in_data == 8'd0) ? RELEASE : DATA;
            end
            DATA: begin
                in_ready = 1'b1;
                xfer     = in_valid;
                if (in_valid) state_next = WRITE;
            end
            WRITE: begin
                mem_we     = 1'b1;
                state_next = ((idx + 8'd1) == len) ? RELEASE : DATA;
            end
            RELEASE: begin
                reset_cycle = 1'b1;
                done        = 1'b1;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign cpu_hold  = busy;
    assign state_dbg = state;

    // mem_addr/mem_data double as the byte latch, so they hold outside WRITE.
    always_ff @(posedge clk) begin
        if (reset) begin
            base     <= '0;
            idx      <= 8'd0;
            len      <= 8'd0;
            mem_addr <= '0;
            mem_data <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base <= base_addr;
                        idx  <= 8'd0;
                    end
                end
                LEN: begin
                    if (xfer) len <= in_data;
                end
                DATA: begin
                    if (xfer) begin
                        mem_data <= in_data;
                        mem_addr <= base + ADDR_W'(idx);
                    end
                end
                WRITE: begin
                    idx <= idx + 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// Directed-plus-random bench for mem_loader: expected RAM writes come from
// base/length/payload arithmetic and are matched against observed mem_we strobes.
module tb_mem_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] base_addr;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] mem_addr;
    logic [7:0] mem_data;
    logic       mem_we;
    logic       cpu_hold;
    logic       reset_cycle;
    logic       done;
    logic       busy;
    logic [2:0] state_dbg;

    mem_loader #(.ADDR_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
        .cpu_hold(cpu_hold), .reset_cycle(reset_cycle), .done(done),
        .busy(busy), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int done_count = 0;
    int rc_count   = 0;
    int act_rd     = 0;
    logic [15:0] act_q[$];
    logic [15:0] exp_q[$];
    logic [7:0]  pay[256];

    always @(posedge clk) begin
        if (mem_we) act_q.push_back({mem_addr, mem_data});
        if (done) done_count <= done_count + 1;
        if (reset_cycle) rc_count <= rc_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] v, input int stall, input bit hold_high);
        bit ok;
        ok = 1'b0;
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            step();
        end
        in_valid = 1'b1;
        in_data  = v;
        for (int t = 0; t < 20 && !ok; t++) begin
            ok = in_ready;
            step();
        end
        if (!ok) check("xfer_timeout", 32'd0, 32'd1);
        in_valid = hold_high;
        in_data  = 8'($urandom);
    endtask

    // Compare everything written since the last scoreboard drain with the model.
    task automatic drain(input string tag);
        int n_act;
        n_act = act_q.size() - act_rd;
        check({tag, "_wr_count"}, 32'(n_act), 32'(exp_q.size()));
        while (exp_q.size() > 0 && act_rd < act_q.size()) begin
            check({tag, "_wr"}, 32'(act_q[act_rd]), 32'(exp_q.pop_front()));
            act_rd++;
        end
        exp_q.delete();
        act_rd = act_q.size();
    endtask

    task automatic load(input string tag, input logic [7:0] b, input logic [7:0] len,
                        input int max_stall, input bit hold_high, input bit poke_start);
        int d0;
        d0 = done_count;
        check({tag, "_idle_before"}, 32'(busy), 32'd0);
        start     = 1'b1;
        base_addr = b;
        step();
        start     = 1'b0;
        base_addr = 8'($urandom);
        check({tag, "_hold_on"}, 32'(cpu_hold), 32'd1);
        send_byte(len, $urandom_range(0, max_stall), hold_high);
        for (int i = 0; i < int'(len); i++) begin
            if (i == 0 && poke_start) begin
                start     = 1'b1;
                base_addr = ~b;
            end
            send_byte(pay[i], $urandom_range(0, max_stall), hold_high);
            start = 1'b0;
            exp_q.push_back({8'(b + 8'(i)), pay[i]});
            check({tag, "_we"}, 32'(mem_we), 32'd1);
            check({tag, "_addr"}, 32'(mem_addr), 32'(8'(b + 8'(i))));
            check({tag, "_data"}, 32'(mem_data), 32'(pay[i]));
            check({tag, "_ready_in_write"}, 32'(in_ready), 32'd0);
            step();
        end
        check({tag, "_rel_done"}, 32'(done), 32'd1);
        check({tag, "_rel_rc"}, 32'(reset_cycle), 32'd1);
        check({tag, "_rel_hold"}, 32'(cpu_hold), 32'd1);
        check({tag, "_rel_we"}, 32'(mem_we), 32'd0);
        in_valid = 1'b0;
        step();
        check({tag, "_post_done"}, 32'(done), 32'd0);
        check({tag, "_post_hold"}, 32'(cpu_hold), 32'd0);
        check({tag, "_post_busy"}, 32'(busy), 32'd0);
        if (len != 8'd0) begin
            check({tag, "_addr_hold"}, 32'(mem_addr), 32'(8'(b + len - 8'd1)));
            check({tag, "_data_hold"}, 32'(mem_data), 32'(pay[len - 8'd1]));
        end
        check({tag, "_done_pulses"}, 32'(done_count - d0), 32'd1);
        drain(tag);
    endtask

    initial begin
        int d0;
        int w0;
        logic [7:0] b;
        reset = 1'b1; start = 1'b0; base_addr = 8'd0; in_data = 8'd0; in_valid = 1'b0;
        step();
        step();
        reset = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_hold", 32'(cpu_hold), 32'd0);
        check("rst_rc", 32'(reset_cycle), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_data", 32'(mem_data), 32'd0);

        // Stray valid bytes in IDLE must be ignored.
        in_valid = 1'b1; in_data = 8'h05;
        repeat (3) step();
        in_valid = 1'b0;
        check("idle_valid_busy", 32'(busy), 32'd0);
        check("idle_valid_writes", 32'(act_q.size()), 32'd0);

        // Reset wins over start on the same edge.
        reset = 1'b1; start = 1'b1;
        step();
        reset = 1'b0; start = 1'b0;
        check("rst_over_start", 32'(busy), 32'd0);

        pay[0] = 8'hA1; pay[1] = 8'hB2; pay[2] = 8'hC3;
        load("basic", 8'h00, 8'd3, 0, 1'b0, 1'b0);
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        load("wrap", 8'hFE, 8'd3, 0, 1'b0, 1'b0);
        load("zero", 8'h40, 8'd0, 0, 1'b0, 1'b0);

        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 256; i++) pay[i] = 8'($urandom);
            load("stall", 8'($urandom), 8'($urandom_range(1, 12)), 3, 1'b1, 1'b0);
        end

        for (int i = 0; i < 256; i++) pay[i] = 8'($urandom);
        load("busy_start", 8'($urandom), 8'd6, 2, 1'b1, 1'b1);

        // Reset after the second of five payload bytes has been written.
        for (int i = 0; i < 5; i++) pay[i] = 8'($urandom);
        b = 8'($urandom);
        d0 = done_count;
        start = 1'b1; base_addr = b;
        step();
        start = 1'b0;
        send_byte(8'd5, 0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            send_byte(pay[i], $urandom_range(0, 2), 1'b0);
            exp_q.push_back({8'(b + 8'(i)), pay[i]});
            step();
        end
        check("midrst_busy_before", 32'(busy), 32'd1);
        reset = 1'b1; in_valid = 1'b1; in_data = 8'h77; start = 1'b1;
        step();
        reset = 1'b0; start = 1'b0;
        check("midrst_hold", 32'(cpu_hold), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd0);
        check("midrst_we", 32'(mem_we), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_rc", 32'(reset_cycle), 32'd0);
        check("midrst_addr", 32'(mem_addr), 32'd0);
        check("midrst_data", 32'(mem_data), 32'd0);
        w0 = act_q.size();
        repeat (4) step();
        in_valid = 1'b0;
        check("midrst_no_more_we", 32'(act_q.size() - w0), 32'd0);
        check("midrst_no_done", 32'(done_count - d0), 32'd0);
        drain("midrst");

        // A clean load still works after the abandoned one.
        for (int i = 0; i < 256; i++) pay[i] = 8'($urandom);
        load("after_rst", 8'($urandom), 8'd4, 1, 1'b0, 1'b0);

        check("rc_matches_done", 32'(rc_count), 32'(done_count));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
